// File: rtl/fp_pkg.sv
// Shared single-precision constants, rounding-mode encodings and the unpacked-operand
// type used by the FPU conversion and arithmetic blocks.
package fp_pkg;

    localparam int unsigned FP_BIAS   = 127;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_SIG_W  = FP_FRAC_W + 1;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_SIG_W-1:0] sig;
        logic                is_nan;
        logic                is_inf;
        logic                is_zero;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a single-precision word into sign, exponent and significand
// (hidden bit restored for normals) plus NaN/Inf/zero classification.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]  fp_i,
    output fp_unpacked_t op_o
);

    logic [FP_EXP_W-1:0]  exp_w;
    logic [FP_FRAC_W-1:0] frac_w;

    assign exp_w  = fp_i[30:23];
    assign frac_w = fp_i[22:0];

    always_comb begin
        op_o.sign    = fp_i[31];
        op_o.exp     = exp_w;
        op_o.sig     = {|exp_w, frac_w};
        op_o.is_nan  = (&exp_w) & (|frac_w);
        op_o.is_inf  = (&exp_w) & ~(|frac_w);
        op_o.is_zero = ~(|fp_i[30:0]);
    end

endmodule

// File: rtl/fp_to_int.sv
// Single-precision to signed 32-bit integer converter: 3-stage valid/ready pipeline
// (unpack, align, round/negate) with rounding-mode select and saturation.
module fp_to_int
    import fp_pkg::*;
#(
    parameter logic [31:0] RESET_OUT = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] fp_i,
    input  logic [1:0]  rm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] int_o,
    output logic        invalid_o,
    output logic        inexact_o
);

    fp_unpacked_t unp_w;
    fp_unpack u_unpack (.fp_i(fp_i), .op_o(unp_w));

    logic         s1_valid_q;
    fp_unpacked_t s1_op_q;
    rm_e          s1_rm_q;

    logic         s2_valid_q, s2_sign_q, s2_guard_q, s2_sticky_q, s2_sat_q, s2_inv_q;
    rm_e          s2_rm_q;
    logic [31:0]  s2_mag_q, s2_satval_q;

    logic         out_valid_q, invalid_q, inexact_q;
    logic [31:0]  int_q;

    // A stage may load whenever it is empty or its contents move on this cycle.
    logic ld1, ld2, ld3;
    assign ld3        = !out_valid_q || out_ready_i;
    assign ld2        = !s2_valid_q || ld3;
    assign ld1        = !s1_valid_q || ld2;
    assign in_ready_o = ld1;

    logic signed [9:0] e_w;
    logic [47:0]       ext_w;
    logic [31:0]       s2_mag_d, s2_satval_d;
    logic              s2_guard_d, s2_sticky_d, s2_sat_d, s2_inv_d;

    assign e_w = $signed({2'b00, s1_op_q.exp}) - $signed(10'(FP_BIAS));

    always_comb begin
        s2_mag_d    = '0;
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
        s2_sat_d    = 1'b0;
        s2_inv_d    = 1'b0;
        s2_satval_d = INT_MAX;
        ext_w       = '0;
        if (s1_op_q.is_nan) begin
            s2_sat_d = 1'b1;
            s2_inv_d = 1'b1;
        end else if (e_w >= 10'sd31) begin
            s2_sat_d    = 1'b1;
            s2_satval_d = s1_op_q.sign ? INT_MIN : INT_MAX;
            // -2^31 is the one e >= 31 value that is representable.
            s2_inv_d    = !(s1_op_q.sign && s1_op_q.exp == 8'd158 && s1_op_q.sig[22:0] == '0);
        end else if (e_w >= 10'sd23) begin
            s2_mag_d = {8'b0, s1_op_q.sig} << 3'(e_w - 10'sd23);
        end else if (e_w >= 10'sd0) begin
            ext_w       = {s1_op_q.sig, 24'b0} >> 5'(10'sd23 - e_w);
            s2_mag_d    = {8'b0, ext_w[47:24]};
            s2_guard_d  = ext_w[23];
            s2_sticky_d = |ext_w[22:0];
        end else begin
            s2_guard_d  = (e_w == -10'sd1);
            s2_sticky_d = (e_w == -10'sd1) ? |s1_op_q.sig[22:0] : |s1_op_q.sig;
        end
    end

    logic        inc_w, lost_w;
    logic [31:0] rounded_w, int_d;

    assign lost_w    = s2_guard_q | s2_sticky_q;
    assign rounded_w = s2_mag_q + {31'b0, inc_w};

    always_comb begin
        case (s2_rm_q)
            RM_RNE:  inc_w = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
            RM_RTZ:  inc_w = 1'b0;
            RM_RDN:  inc_w = s2_sign_q & lost_w;
            RM_RUP:  inc_w = ~s2_sign_q & lost_w;
            default: inc_w = 1'b0;
        endcase
        if (s2_sat_q)
            int_d = s2_satval_q;
        else
            int_d = s2_sign_q ? (32'd0 - rounded_w) : rounded_w;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_rm_q     <= RM_RNE;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_sat_q    <= 1'b0;
            s2_inv_q    <= 1'b0;
            s2_rm_q     <= RM_RNE;
            s2_mag_q    <= '0;
            s2_satval_q <= '0;
            out_valid_q <= 1'b0;
            int_q       <= RESET_OUT;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            if (ld1) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_op_q <= unp_w;
                    s1_rm_q <= rm_e'(rm_i);
                end
            end
            if (ld2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q   <= s1_op_q.sign;
                    s2_rm_q     <= s1_rm_q;
                    s2_mag_q    <= s2_mag_d;
                    s2_guard_q  <= s2_guard_d;
                    s2_sticky_q <= s2_sticky_d;
                    s2_sat_q    <= s2_sat_d;
                    s2_inv_q    <= s2_inv_d;
                    s2_satval_q <= s2_satval_d;
                end
            end
            if (ld3) begin
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    int_q     <= int_d;
                    invalid_q <= s2_sat_q & s2_inv_q;
                    inexact_q <= !s2_sat_q && lost_w;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign int_o       = int_q;
    assign invalid_o   = invalid_q;
    assign inexact_o   = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed bench for fp_to_int: conversion vectors, latency, backpressure and mid-stream reset.
module tb_fp_to_int;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RDN = 2'b10, RUP = 2'b11;
    localparam logic [31:0] RST_VAL = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp = '0;
    logic [1:0]  rm = RNE;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] int_res;
    logic        invalid, inexact;

    int errors = 0;
    int checks = 0;

    fp_to_int #(.RESET_OUT(RST_VAL)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .fp_i       (fp),
        .rm_i       (rm),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .int_o      (int_res),
        .invalid_o  (invalid),
        .inexact_o  (inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the pipeline empty.
    task automatic run_one(input string tag, input logic [31:0] f, input logic [1:0] r,
                           input logic [31:0] exp_int, input logic exp_inv, input logic exp_inx);
        int lat;
        in_valid  = 1'b1;
        fp        = f;
        rm        = r;
        out_ready = 1'b1;
        check($sformatf("%s_rdy", tag), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        fp       = 32'hDEAD_BEEF;
        rm       = ~r;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s_lat", tag), 32'(lat), 32'd3);
        check($sformatf("%s_int", tag), int_res, exp_int);
        check($sformatf("%s_inv", tag), 32'(invalid), 32'(exp_inv));
        check($sformatf("%s_inx", tag), 32'(inexact), 32'(exp_inx));
        @(posedge clk); #1;
    endtask

    logic [31:0] s_fp  [8];
    logic [1:0]  s_rm  [8];
    logic [31:0] s_exp [8];

    initial begin
        int ai, oi;
        bit saw_block, held;
        logic [31:0] held_val;

        s_fp[0] = 32'h3F80_0000; s_rm[0] = RNE; s_exp[0] = 32'd1;
        s_fp[1] = 32'h4020_0000; s_rm[1] = RUP; s_exp[1] = 32'd3;
        s_fp[2] = 32'h4020_0000; s_rm[2] = RTZ; s_exp[2] = 32'd2;
        s_fp[3] = 32'hC020_0000; s_rm[3] = RDN; s_exp[3] = 32'hFFFF_FFFD;
        s_fp[4] = 32'h40A0_0000; s_rm[4] = RNE; s_exp[4] = 32'd5;
        s_fp[5] = 32'h40C0_0000; s_rm[5] = RNE; s_exp[5] = 32'd6;
        s_fp[6] = 32'h40E0_0000; s_rm[6] = RNE; s_exp[6] = 32'd7;
        s_fp[7] = 32'h4100_0000; s_rm[7] = RNE; s_exp[7] = 32'd8;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_int", int_res, RST_VAL);
        check("rst_flags", {30'b0, invalid, inexact}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy", 32'(in_ready), 32'd1);

        run_one("neg1916", 32'hC4EF_8000, RNE, 32'hFFFF_F884, 1'b0, 1'b0);
        run_one("p2_5_rne", 32'h4020_0000, RNE, 32'd2, 1'b0, 1'b1);
        run_one("p2_5_rtz", 32'h4020_0000, RTZ, 32'd2, 1'b0, 1'b1);
        run_one("p2_5_rup", 32'h4020_0000, RUP, 32'd3, 1'b0, 1'b1);
        run_one("n2_5_rdn", 32'hC020_0000, RDN, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run_one("p2_31", 32'h4F00_0000, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_one("n2_31", 32'hCF00_0000, RNE, 32'h8000_0000, 1'b0, 1'b0);
        run_one("max_exact", 32'h4EFF_FFFF, RNE, 32'h7FFF_FF80, 1'b0, 1'b0);
        run_one("nan", 32'h7FC0_0000, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_one("ninf", 32'hFF80_0000, RNE, 32'h8000_0000, 1'b1, 1'b0);
        run_one("p0_4_rne", 32'h3ECC_CCCD, RNE, 32'd0, 1'b0, 1'b1);
        run_one("n0_4_rdn", 32'hBECC_CCCD, RDN, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_one("n0_4_rtz", 32'hBECC_CCCD, RTZ, 32'd0, 1'b0, 1'b1);
        run_one("nzero", 32'h8000_0000, RDN, 32'd0, 1'b0, 1'b0);
        run_one("half_rne", 32'h3F00_0000, RNE, 32'd0, 1'b0, 1'b1);
        run_one("half_rup", 32'h3F00_0000, RUP, 32'd1, 1'b0, 1'b1);

        // Back-to-back stream with the consumer stalled for cycles 4..7.
        ai = 0; oi = 0; saw_block = 0; held = 0; held_val = '0;
        for (int cyc = 0; cyc < 40 && oi < 8; cyc++) begin
            in_valid = (ai < 8);
            if (ai < 8) begin
                fp = s_fp[ai];
                rm = s_rm[ai];
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            #4;
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", int_res, held_val);
            end
            check($sformatf("stream_rdy_c%0d", cyc), 32'(in_ready),
                  32'(!((ai - oi) == 3 && !out_ready)));
            if (!in_ready) saw_block = 1;
            held     = out_valid && !out_ready;
            held_val = int_res;
            if (out_valid && out_ready) begin
                if (oi < 8) check($sformatf("stream_out%0d", oi), int_res, s_exp[oi]);
                oi++;
            end
            if (in_valid && in_ready) ai++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(oi), 32'd8);
        check("stream_block", 32'(saw_block), 32'd1);
        @(posedge clk); #1;
        check("stream_drained", 32'(out_valid), 32'd0);

        // Reset with three operands in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            fp       = (k == 0) ? 32'h4020_0000 : 32'h40A0_0000;
            rm       = RUP;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_int", int_res, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_int", int_res, RST_VAL);
        check("midrst_flags", {30'b0, invalid, inexact}, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("postrst_valid", 32'(out_valid), 32'd0);
        check("postrst_rdy", 32'(in_ready), 32'd1);
        run_one("postrst", 32'h4100_0000, RNE, 32'd8, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Converts IEEE-754 single-precision operands to signed 32-bit two's-complement integers; it is the inverse companion of `int_to_fp` in the FPU conversion path. A 3-stage valid/ready pipeline (unpack, align, round/negate) with selectable rounding mode, saturation on out-of-range inputs, and invalid/inexact exception flags. The block sits between the FPU register-file read port and the integer writeback mux.

## Interface
- `RESET_OUT`, 32'h0000_0000: value driven on `int` while in reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `fp`/`rm` are valid this cycle.
- `in_ready`  out  1  stage 1 can accept; transfer when `in_valid && in_ready`.
- `fp`  in  32  single-precision operand.
- `rm`  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf).
- `out_valid`  out  1  `int`/flags valid.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid && out_ready`.
- `int`  out  32  signed result.
- `invalid`  out  1  NaN or out-of-range input; result saturated.
- `inexact`  out  1  discarded fraction bits nonzero and `invalid` = 0.

## Operation
- Stage 1 (unpack): sign, 8-bit exp, 24-bit significand with hidden bit (hidden = 0 when exp = 0; subnormals treated as tiny nonzero values). Classify: NaN (exp = 255, frac ≠ 0), Inf (exp = 255, frac = 0), zero.
- Stage 2 (align): e = exp − 127 (signed 9-bit).
  - e ≥ 31: overflow, except exactly sign = 1, exp = 158, frac = 0 (−2^31), which is exact.
  - 0 ≤ e ≤ 30: magnitude = significand shifted left (e ≥ 23) or right (e < 23). Bits shifted out form guard (MSB discarded) and sticky (OR of the rest).
  - e < 0: magnitude = 0, guard = (e = −1), sticky = OR of the remaining significand bits.
- Stage 3 (round/negate): increment = RNE: guard & (sticky | lsb); RTZ: 0; RDN: sign & (guard | sticky); RUP: ~sign & (guard | sticky). Add increment to the magnitude, then negate if sign = 1. A rounded magnitude cannot exceed 2^31 − 1 because only e ≤ 22 rounds.
- Saturation: NaN, +Inf, or positive overflow gives 32'h7FFF_FFFF; −Inf or negative overflow gives 32'h8000_0000. In all these cases `invalid` = 1 and `inexact` = 0.
- ±0 gives 0 with no flags. −0.x rounded to 0 gives 0 (there is no negative zero in integers).
- `rm` is sampled with `fp` and travels through the pipeline with it. Changing `rm` mid-flight does not affect operands already accepted.

## Timing
- Latency is 3 cycles from input transfer to `out_valid` when there is no backpressure. Throughput is 1 per cycle.
- Each stage has its own valid bit. Stall = `out_valid && !out_ready`. On stall, a stage holds unless the stage downstream of it is empty (bubbles collapse). `in_ready` = !stage1_valid || stage1 advances.
- `in_ready` is combinational from `out_ready` and the stage valid bits. It never depends on `in_valid`.
- Once `out_valid` is high, `int`, `invalid`, and `inexact` stay stable until transfer.
- Reset (asynchronous assert, any cycle including mid-stream): all stage valid bits clear, `out_valid` = 0, `int` = `RESET_OUT`, `invalid` = `inexact` = 0. In-flight operands are discarded with no partial outputs. `in_ready` = 1 from the first edge after reset deassertion.
- Simultaneous input accept and output transfer in the same cycle is supported with no bubble.

## Structure
- Shared package `fp_pkg` holds:
  - `FP_BIAS` = 127, `FP_EXP_W` = 8, `FP_FRAC_W` = 23.
  - Rounding-mode encodings `RM_RNE`, `RM_RTZ`, `RM_RDN`, `RM_RUP`.
  - `INT_MAX` and `INT_MIN` saturation constants.
  - The unpacked-operand struct (sign, exp, significand, class bits).
- Sub-module `fp_unpack`: combinational field split and classification. It is reused by `int_to_fp` and the adder, and instantiated in stage 1.
- The remaining stages are written inline in `fp_to_int`.

## Test plan
- 0xC4EF8000 (−1916.0), RNE → `int` = 0xFFFFF884, no flags, `out_valid` exactly 3 cycles after accept.
- 0x40200000 (2.5): RNE → 2, RTZ → 2, RUP → 3, each with `inexact` = 1. 0xC0200000 (−2.5), RDN → 0xFFFFFFFD, `inexact` = 1.
- 0x4F000000 (2^31) → 0x7FFFFFFF, `invalid` = 1. 0xCF000000 (−2^31) → 0x80000000, no flags. 0x7FC00000 (NaN) → 0x7FFFFFFF, `invalid` = 1. 0xFF800000 (−Inf) → 0x80000000, `invalid` = 1.
- 0x3ECCCCCD (0.4), RNE → 0, `inexact` = 1. 0xBECCCCCD (−0.4): RDN → 0xFFFFFFFF, RTZ → 0. 0x80000000 (−0) → 0, no flags.
- Stream of 8 back-to-back operands with `out_ready` low for cycles 4–7: `in_ready` drops once all 3 stages are full, no result is lost or duplicated, and results appear in order with a stable `int` while stalled.
- Assert `reset` while 3 operands are in flight: `out_valid` = 0 and `int` = `RESET_OUT` immediately; after release, the first new operand emerges 3 cycles after accept with no stale data.
